// File: rtl/minon_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : minon_pkg
// Purpose  : Shared widths, reservation-station entry type and arithmetic op
//            encoding for the integer execution units.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package minon_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_TAG_W = 8;

    typedef struct packed {
        logic                     busy;
        logic [DEFAULT_TAG_W-1:0] alu1;
        logic [DEFAULT_TAG_W-1:0] alu2;
        logic [DEFAULT_WIDTH-1:0] value1;
        logic [DEFAULT_WIDTH-1:0] value2;
    } rs_entry_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } arith_op_e;

endpackage : minon_pkg
`default_nettype wire

// File: rtl/arith_delay_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : arith_delay_line
// Purpose  : LATENCY-deep valid/data shift register; the last stage data
//            holds until the next valid word reaches it.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module arith_delay_line #(
    parameter int LATENCY = 1,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [LATENCY-1:0]         valid_q, valid_d;
    logic [LATENCY-1:0][DW-1:0] data_q, data_d;

    // Data only advances alongside a valid bit, so the output stage keeps
    // the last delivered result between strobes.
    always_comb begin
        valid_d    = '0;
        data_d     = data_q;
        valid_d[0] = in_valid;
        if (in_valid) begin
            data_d[0] = in_data;
        end
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule : arith_delay_line
`default_nettype wire

// File: rtl/rs_arith_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rs_arith_unit
// Purpose  : Add/subtract execution unit behind one reservation-station slot,
//            one CDB strobe per slot occupancy. Optional macro ALU_OVF_EN
//            adds the result_overflow output.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module rs_arith_unit
    import minon_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TAG_W   = DEFAULT_TAG_W,
    parameter int OP      = 0,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rs_busy,
    input  logic [TAG_W-1:0] rs_alu1,
    input  logic [TAG_W-1:0] rs_alu2,
    input  logic [WIDTH-1:0] rs_value1,
    input  logic [WIDTH-1:0] rs_value2,
    output logic [WIDTH-1:0] result,
`ifdef ALU_OVF_EN
    output logic             result_overflow,
`endif
    output logic             result_available
);

    localparam arith_op_e OP_SEL = (OP == 1) ? OP_SUB : OP_ADD;

`ifdef ALU_OVF_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif

    logic             issued_q, issued_d;
    logic             issue;
    logic [WIDTH-1:0] calc;
    logic [DW-1:0]    payload;
    logic [DW-1:0]    out_data;

    // issued latches for the whole occupancy so a held slot fires only once.
    always_comb begin
        issue    = rs_busy && (rs_alu1 == '0) && (rs_alu2 == '0) && !issued_q;
        issued_d = issued_q;
        if (issue) begin
            issued_d = 1'b1;
        end else if (!rs_busy) begin
            issued_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= 1'b0;
        end else begin
            issued_q <= issued_d;
        end
    end

    always_comb begin
        calc = (OP_SEL == OP_SUB) ? (rs_value1 - rs_value2) : (rs_value1 + rs_value2);
    end

`ifdef ALU_OVF_EN
    logic ovf;
    // Signed overflow: result sign differs from operand 1 when the effective
    // operands share a sign.
    always_comb begin
        if (OP_SEL == OP_SUB) begin
            ovf = (rs_value1[WIDTH-1] != rs_value2[WIDTH-1]) && (calc[WIDTH-1] != rs_value1[WIDTH-1]);
        end else begin
            ovf = (rs_value1[WIDTH-1] == rs_value2[WIDTH-1]) && (calc[WIDTH-1] != rs_value1[WIDTH-1]);
        end
        payload = {ovf, calc};
    end
    assign result_overflow = out_data[WIDTH];
`else
    always_comb begin
        payload = calc;
    end
`endif

    arith_delay_line #(
        .LATENCY (LATENCY),
        .DW      (DW)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_data   (payload),
        .out_valid (result_available),
        .out_data  (out_data)
    );

    assign result = out_data[WIDTH-1:0];

endmodule : rs_arith_unit
`default_nettype wire

// File: tb/tb_rs_arith_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_rs_arith_unit
// Purpose  : Directed self-checking bench for rs_arith_unit (add L1, sub L1,
//            add L3 instances sharing one set of slot inputs).
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_rs_arith_unit;

    logic        clk;
    logic        rst;
    logic        rs_busy;
    logic [7:0]  rs_alu1;
    logic [7:0]  rs_alu2;
    logic [31:0] rs_value1;
    logic [31:0] rs_value2;

    logic [31:0] add_result, sub_result, add3_result;
    logic        add_avail, sub_avail, add3_avail;
`ifdef ALU_OVF_EN
    logic        add_ovf, sub_ovf, add3_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int strobes_add;
    int strobes_add3;

    rs_arith_unit #(.WIDTH(32), .TAG_W(8), .OP(0), .LATENCY(1)) u_add (
        .clk(clk), .rst(rst), .rs_busy(rs_busy), .rs_alu1(rs_alu1), .rs_alu2(rs_alu2),
        .rs_value1(rs_value1), .rs_value2(rs_value2), .result(add_result),
`ifdef ALU_OVF_EN
        .result_overflow(add_ovf),
`endif
        .result_available(add_avail)
    );

    rs_arith_unit #(.WIDTH(32), .TAG_W(8), .OP(1), .LATENCY(1)) u_sub (
        .clk(clk), .rst(rst), .rs_busy(rs_busy), .rs_alu1(rs_alu1), .rs_alu2(rs_alu2),
        .rs_value1(rs_value1), .rs_value2(rs_value2), .result(sub_result),
`ifdef ALU_OVF_EN
        .result_overflow(sub_ovf),
`endif
        .result_available(sub_avail)
    );

    rs_arith_unit #(.WIDTH(32), .TAG_W(8), .OP(0), .LATENCY(3)) u_add3 (
        .clk(clk), .rst(rst), .rs_busy(rs_busy), .rs_alu1(rs_alu1), .rs_alu2(rs_alu2),
        .rs_value1(rs_value1), .rs_value2(rs_value2), .result(add3_result),
`ifdef ALU_OVF_EN
        .result_overflow(add3_ovf),
`endif
        .result_available(add3_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, drop busy right away, and follow the L1 and L3 strobes.
    task automatic run_op(input string tag, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] exp_add, input logic [31:0] exp_sub);
        rs_busy = 1'b1; rs_alu1 = 8'd0; rs_alu2 = 8'd0;
        rs_value1 = v1; rs_value2 = v2;
        tick();
        check({tag, "_add_avail"}, {31'd0, add_avail}, 32'd1);
        check({tag, "_add"}, add_result, exp_add);
        check({tag, "_sub_avail"}, {31'd0, sub_avail}, 32'd1);
        check({tag, "_sub"}, sub_result, exp_sub);
        check({tag, "_l3_early"}, {31'd0, add3_avail}, 32'd0);
        rs_busy = 1'b0; rs_value1 = 32'hDEAD_BEEF; rs_value2 = 32'h1234_5678;
        tick();
        check({tag, "_add_single"}, {31'd0, add_avail}, 32'd0);
        check({tag, "_l3_early2"}, {31'd0, add3_avail}, 32'd0);
        tick();
        check({tag, "_l3_avail"}, {31'd0, add3_avail}, 32'd1);
        check({tag, "_l3"}, add3_result, exp_add);
        tick();
        check({tag, "_l3_single"}, {31'd0, add3_avail}, 32'd0);
        check({tag, "_add_hold"}, add_result, exp_add);
    endtask

    initial begin
        rst = 1'b1; rs_busy = 1'b0; rs_alu1 = 8'd0; rs_alu2 = 8'd0;
        rs_value1 = 32'd0; rs_value2 = 32'd0;
        tick();
        tick();
        check("rst_add", add_result, 32'd0);
        check("rst_add_avail", {31'd0, add_avail}, 32'd0);
        check("rst_sub", sub_result, 32'd0);
        check("rst_l3_avail", {31'd0, add3_avail}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_avail", {31'd0, add_avail}, 32'd0);

        run_op("v57", 32'd5, 32'd7, 32'd12, 32'hFFFF_FFFE);
        run_op("v35", 32'd3, 32'd5, 32'd8, 32'hFFFF_FFFE);
        run_op("wrap", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFE);
        run_op("zero_minus1", 32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF);

        // Operand 1 still pending: nothing may issue.
        rs_busy = 1'b1; rs_alu1 = 8'd3; rs_alu2 = 8'd0;
        rs_value1 = 32'd99; rs_value2 = 32'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wait_sub_avail", {31'd0, sub_avail}, 32'd0);
            check("wait_l3_avail", {31'd0, add3_avail}, 32'd0);
        end
        rs_alu1 = 8'd0; rs_value1 = 32'd10;
        tick();
        check("wait_sub_done", {31'd0, sub_avail}, 32'd1);
        check("wait_sub", sub_result, 32'd6);
        tick();
        check("wait_sub_once", {31'd0, sub_avail}, 32'd0);
        rs_busy = 1'b0;
        tick();
        tick();

        // Busy held for ten cycles: exactly one strobe per unit.
        strobes_add = 0;
        strobes_add3 = 0;
        rs_busy = 1'b1; rs_alu1 = 8'd0; rs_alu2 = 8'd0;
        rs_value1 = 32'd1; rs_value2 = 32'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (add_avail) strobes_add++;
            if (add3_avail) strobes_add3++;
        end
        check("hold_strobes", strobes_add, 32'd1);
        check("hold_l3_strobes", strobes_add3, 32'd1);
        rs_busy = 1'b0; rs_value1 = 32'd7; rs_value2 = 32'd7;
        tick();
        check("drop_avail", {31'd0, add_avail}, 32'd0);
        rs_busy = 1'b1; rs_value1 = 32'd1; rs_value2 = 32'd1;
        tick();
        check("reissue_avail", {31'd0, add_avail}, 32'd1);
        check("reissue", add_result, 32'd2);
        check("reissue_sub", sub_result, 32'd0);
        rs_busy = 1'b0;
        tick();
        tick();
        tick();
        tick();

        // Reset one cycle into a latency-3 op: the strobe must never appear.
        rs_busy = 1'b1; rs_value1 = 32'd5; rs_value2 = 32'd5;
        tick();
        rst = 1'b1; rs_busy = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_l3_avail", {31'd0, add3_avail}, 32'd0);
            check("rst_mid_l3", add3_result, 32'd0);
            tick();
        end
        check("rst_mid_add", add_result, 32'd0);

`ifdef ALU_OVF_EN
        rs_busy = 1'b1; rs_value1 = 32'h7FFF_FFFF; rs_value2 = 32'd1;
        tick();
        check("ovf_add", {31'd0, add_ovf}, 32'd1);
        check("ovf_add_res", add_result, 32'h8000_0000);
        check("ovf_sub", {31'd0, sub_ovf}, 32'd0);
        rs_busy = 1'b0;
        tick();
        rs_busy = 1'b1; rs_value1 = 32'h8000_0000; rs_value2 = 32'd1;
        tick();
        check("ovf_sub_neg", {31'd0, sub_ovf}, 32'd1);
        check("ovf_add_none", {31'd0, add_ovf}, 32'd0);
        rs_busy = 1'b0;
        tick();
        tick();
        tick();
        check("ovf_l3", {31'd0, add3_ovf}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rs_arith_unit
`default_nettype wire
